cdb_arbiter: RTL
================

# cdb_arbiter

Writeback stage directly downstream of the functional-unit wrapper. It accepts up to SS completed results per cycle, one per FU lane, into per-lane FIFOs. It arbitrates round-robin among the non-empty lanes and drives up to CDB_WIDTH registered broadcasts per cycle on the common data bus, which the ROB, reservation stations and physical register file consume. When a lane's FIFO is full, it backpressures that FU lane.

## Interface
Parameters:
- SS, 2: number of FU lanes (inputs).
- CDB_WIDTH, 2: number of broadcast slots per cycle; 1 ≤ CDB_WIDTH ≤ SS.
- QUEUE_DEPTH, 4: entries per lane FIFO; power of two, ≥ 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, input, 1: clock.
  - rst, input, 1: synchronous, active-high reset.
- fu_valid, input, [SS]×1: lane i presents a finished result this cycle.
- fu_result, input, [SS]×cdb_entry_t: the result payload.
- fu_ready, output, [SS]×1: lane i FIFO can accept; depends only on registered state.
- flush, input, 1: mispredict squash; discards everything queued and in flight.
- cdb_valid, output, [CDB_WIDTH]×1: slot carries a broadcast; registered.
- cdb_out, output, [CDB_WIDTH]×cdb_entry_t: broadcast payload; registered.

## Operation
- **Enqueue.** Lane i writes fu_result[i] at the rising edge when fu_valid[i] && fu_ready[i]. fu_valid while fu_ready=0 is ignored, and the FU must hold the result.
- **fu_ready.** fu_ready[i] = (count[i] != QUEUE_DEPTH). There is no look-through: a full FIFO that is dequeued this cycle still reports not-ready this cycle.
- **Per-lane FIFO.**
  - Storage: head pointer, tail pointer, and count of width $clog2(QUEUE_DEPTH)+1.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Simultaneous enqueue and dequeue on a non-full FIFO leaves count unchanged.
  - Empty-FIFO dequeue never occurs.
- **Selection** (combinational, from registered state):
  - Scan lanes starting at rr_ptr, wrapping, and grant the first ≤ CDB_WIDTH non-empty lanes.
  - Slots fill in scan order: slot 0 takes the first grant.
  - Each granted lane pops its head entry.
- **rr_ptr.** Updates to (last granted lane + 1) mod SS. If nothing is granted, it holds.
- **Broadcast.** Granted head entries are registered into cdb_out at the edge. Ungranted slots get cdb_valid=0, and cdb_out holds its previous value (don't-care).
- **Ordering.** Results within one lane broadcast in FIFO order. There is no ordering across lanes.
- **Flush.** At the edge where flush=1:
  - all counts go to 0, and head/tail go to 0;
  - all cdb_valid go to 0;
  - same-cycle enqueues are dropped;
  - rr_ptr holds.
- **Reset.** Same clearing as flush, plus rr_ptr=0 and cdb_out=0. After reset, fu_ready is all 1.

## Timing
- **Latency.** A result enqueued at edge t appears on cdb at edge t+1 at the earliest, when its lane is granted in cycle t..t+1. There is no combinational bypass from fu_valid to cdb.
- **Throughput.** min(CDB_WIDTH, non-empty lanes) broadcasts per cycle.
- **Steady state.** The sustained rate is CDB_WIDTH; with SS=CDB_WIDTH, a continuously valid FU sees no stall.
- **Backpressure.** fu_ready deasserts the cycle after the edge that fills the FIFO. It reasserts the cycle after the edge that dequeues from a full FIFO.
- **Priority.** rst > flush > normal operation.

## Structure
- rv32i_types gains:
  - cdb_entry_t {rob_id, pd (physical dest), rd (arch dest), register_value[31:0], br_en, regf_we}.
  - localparam CDB_WIDTH.
- One sub-module, result_fifo (parameter DEPTH, type cdb_entry_t). It has push/pop/flush inputs and full/empty/count/head outputs, and is instantiated SS times in a generate loop.
- The top level contains the round-robin scan, rr_ptr register and cdb output registers.

## Test plan
- **Single result.** After reset, lane 0 sends rob_id=3, value=0xDEADBEEF for one cycle → next cycle cdb_valid[0]=1 with the same payload; cdb_valid[1]=0.
- **Both lanes.** Both lanes valid for 4 cycles, CDB_WIDTH=2 → 8 broadcasts in 4 consecutive cycles; fu_ready stays 1 throughout; per-lane order is preserved.
- **Fill and drain.** CDB_WIDTH=1, both lanes valid continuously → each lane alternates grants. After lane FIFOs fill, fu_ready drops and data is neither lost nor duplicated; total out = total accepted.
- **Full with simultaneous pop.** Lane 0 FIFO full with a dequeue this cycle → fu_ready[0]=0 this cycle, 1 next cycle; count returns to QUEUE_DEPTH-1.
- **Flush mid-operation.** 3 entries queued in lane 1 and a new result arriving while flush=1 → next cycle all cdb_valid=0, fu_ready all 1, and no stale broadcast afterwards.
- **Reset mid-operation.** Reset asserted with queued entries → outputs zero and empty, rr_ptr=0; the first post-reset grant goes to lane 0 when both lanes are valid.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizing for the common-data-bus writeback stage.
package cdb_arbiter_pkg;

  localparam int ROB_ID_W   = 4;
  localparam int PHYS_REG_W = 6;
  localparam int ARCH_REG_W = 5;

  localparam int DEF_SS          = 2;
  localparam int DEF_CDB_WIDTH   = 2;
  localparam int DEF_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [ROB_ID_W-1:0]   rob_id;
    logic [PHYS_REG_W-1:0] pd;
    logic [ARCH_REG_W-1:0] rd;
    logic [31:0]           register_value;
    logic                  br_en;
    logic                  regf_we;
  } cdb_entry_t;

  // Index width for n items, never narrower than one bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-lane results in, CDB broadcasts out; master is the producer/consumer side.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int SS        = DEF_SS,
  parameter int CDB_WIDTH = DEF_CDB_WIDTH
) ();

  logic [SS-1:0]        fu_valid;
  cdb_entry_t           fu_result [SS];
  logic [SS-1:0]        fu_ready;
  logic                 flush;
  logic [CDB_WIDTH-1:0] cdb_valid;
  cdb_entry_t           cdb_out [CDB_WIDTH];

  modport master (
    output fu_valid, fu_result, flush,
    input  fu_ready, cdb_valid, cdb_out
  );

  modport slave (
    input  fu_valid, fu_result, flush,
    output fu_ready, cdb_valid, cdb_out
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-lane result FIFO: circular buffer with head/tail pointers and an occupancy count.
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int  DEPTH = DEF_QUEUE_DEPTH,
  parameter type T     = cdb_entry_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  T                 data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output T                 head_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: payload storage has no reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= data_i;
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: per-lane FIFOs, round-robin pick of up to CDB_WIDTH lanes, registered CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int SS          = DEF_SS,
  parameter int CDB_WIDTH   = DEF_CDB_WIDTH,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  localparam int LANE_W = lane_w(SS);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;

  typedef logic [LANE_W-1:0] lane_t;

  logic [SS-1:0]    fifo_full, fifo_empty, grant;
  logic [CNT_W-1:0] fifo_count [SS];
  cdb_entry_t       fifo_head  [SS];

  for (genvar i = 0; i < SS; i++) begin : g_lane
    result_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .T     (cdb_entry_t)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.fu_valid[i] && !fifo_full[i]),
      .pop_i   (grant[i]),
      .flush_i (bus.flush),
      .data_i  (bus.fu_result[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .count_o (fifo_count[i]),
      .head_o  (fifo_head[i])
    );

    assign bus.fu_ready[i] = (fifo_count[i] != CNT_W'(QUEUE_DEPTH));
  end

  lane_t                rr_ptr_q, rr_ptr_d;
  lane_t                lane;
  lane_t                slot_lane [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] slot_valid;
  logic [CDB_WIDTH-1:0] cdb_valid_q;
  cdb_entry_t           cdb_out_q [CDB_WIDTH];

  // Each slot takes the next non-empty, not-yet-granted lane in scan order from rr_ptr.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    grant      = '0;
    slot_valid = '0;
    rr_ptr_d   = rr_ptr_q;
    lane       = '0;
    for (int s = 0; s < CDB_WIDTH; s++) slot_lane[s] = '0;
    for (int s = 0; s < CDB_WIDTH; s++) begin
      for (int k = 0; k < SS; k++) begin
        lane = lane_t'((int'(rr_ptr_q) + k) % SS);
        if (!slot_valid[s] && !fifo_empty[lane] && !grant[lane]) begin
          grant[lane]   = 1'b1;
          slot_valid[s] = 1'b1;
          slot_lane[s]  = lane;
          rr_ptr_d      = lane_t'((int'(lane) + 1) % SS);
        end
      end
    end
  end

  // Flush squashes the broadcast but keeps fairness state; the FIFOs discard their own pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      for (int s = 0; s < CDB_WIDTH; s++) cdb_out_q[s] <= '0;
    end else if (bus.flush) begin
      cdb_valid_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= slot_valid;
      for (int s = 0; s < CDB_WIDTH; s++) begin
        if (slot_valid[s]) cdb_out_q[s] <= fifo_head[slot_lane[s]];
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_out   = cdb_out_q;

endmodule
